regbank_sequencer: RTL
======================

# regbank_sequencer

Command-driven initiator for the 8×8-bit two-read/one-write register bank. It accepts one register-to-register or immediate command per handshake, drives the bank's read addresses, captures both operands, and computes an 8-bit ALU result. It writes the result back through the bank's write port and returns the result upstream on a response handshake. It sits between the control/decode logic and the register bank, and is the only master of the bank's address and write ports.

## Interface
- No parameters; widths fixed: 8-bit data, 3-bit register address.
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  3  opcode; see Operation
- cmd_rd  in  3  destination register
- cmd_rs1, cmd_rs2  in  3 each  source registers
- cmd_imm  in  8  immediate
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  8  result, or read value for RD
- rsp_carry  out  1  carry (ADD/ADDI) or borrow (SUB); 0 for other ops
- reg_addr_1, reg_addr_2  out  3 each  bank read addresses
- reg_data_1, reg_data_2  in  8 each  bank read data, combinational from bank registers
- write_enable  out  1  bank write strobe
- write_addr  out  3  bank write address
- write_data  out  8  bank write data

## Operation
- Opcodes:
  - 000 ADD: rs1+rs2
  - 001 SUB: rs1−rs2
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 LDI: imm
  - 110 ADDI: rs1+imm
  - 111 RD: no write; rsp_data = rs1 value
- All arithmetic is modulo 256.
  - ADD/ADDI: carry = bit 8 of the 9-bit sum.
  - SUB: carry = 1 when rs1 < rs2 (unsigned).
- Register 0 reads as 0. Any command with rd=0 performs no write; write_enable stays 0. The bank aliases writes to address 0 onto register 1, so this suppression is mandatory. The response is still produced.
- FSM states: IDLE, OPER, EXEC, WAIT1, WAIT2, RESP.
  - IDLE: cmd_ready=1. On cmd_valid, latch all cmd fields and go to OPER.
  - OPER: drive reg_addr_1=rs1, reg_addr_2=rs2. Capture reg_data_1/2 at the end of the cycle. Go to EXEC.
  - EXEC: compute the result and load rsp_data/rsp_carry.
    - If the op writes and rd≠0: write_enable=1, write_addr=rd, write_data=result for exactly this cycle, then go to WAIT1.
    - Otherwise go to RESP.
  - WAIT1 → WAIT2 → RESP unconditionally. These cover the bank's 2-edge write-to-read latency.
  - RESP: rsp_valid=1. rsp_data/rsp_carry are held stable. When rsp_ready is high, go to IDLE.
- Outside OPER, reg_addr_1/2=0. Outside EXEC, write_enable=0, write_addr=0, write_data=0.
- cmd_ready=0 in every state except IDLE. Only one command is in flight at a time.

## Timing
- Reset: state IDLE. After reset: cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_carry=0, all bank-side outputs 0. During a reset cycle, cmd_ready=0.
- Accept on edge T0 (IDLE, cmd_valid=1):
  - OPER in cycle T0+1, EXEC in T0+2.
  - Writing command: rsp_valid from T0+5.
  - Non-writing command (RD, or rd=0): rsp_valid from T0+3.
- When rsp_ready=1 in the first RESP cycle, cmd_ready rises the next cycle. Back-to-back writing commands therefore run at 1 command per 6 cycles.
- RESP with rsp_ready=0: hold indefinitely; outputs must not change.
- Reset mid-operation: the command is abandoned, any pending write is dropped, and the FSM goes to IDLE on the same edge.

## Configuration
- Macro REGBANK_SEQUENCER_FWD_EN.
- Defined:
  - EXEC goes directly to RESP; WAIT1/WAIT2 are removed.
  - A forwarding entry (addr, data, 2-bit life counter) is loaded on every write and set to life=2.
  - The counter decrements each cycle. Reset clears it to 0.
  - In OPER, when life≠0 and rs1 or rs2 matches the entry's addr, the forwarded data replaces the bank data for that operand. rs=0 never forwards.
  - Writing commands respond at T0+3.
- Undefined: no forwarding logic; WAIT states present; timing exactly as above.

## Test plan
- Reset, then LDI rd=3 imm=0x7F, then RD rs1=3 → first rsp 0x7F; RD rsp 0x7F; write_enable high exactly 1 cycle, write_addr=3.
- r1=0xF0, r2=0x20; ADD rd=4 → rsp_data 0x10, rsp_carry 1; SUB rs1=2 rs2=1 → 0x30, carry 1.
- LDI rd=0 imm=0x55 → no write_enable pulse; RD rs1=1 unchanged; RD rs1=0 → 0x00.
- Back-to-back LDI rd=5 0xAA, then ADDI rd=6 rs1=5 imm=0x01 → 0xAB, with and without FWD_EN. Response latency is 5 cycles without FWD_EN and 3 cycles with it.
- Hold rsp_ready=0 for 10 cycles in RESP → rsp_valid and rsp_data stable, cmd_ready=0; release → cmd_ready=1 the next cycle.
- Assert rst during EXEC of a writing command → no further write_enable, rsp_valid=0, cmd_ready=1 one cycle after rst drops.

Source files
------------

// File: rtl/regbank_sequencer.sv
// Command sequencer for the 8x8 two-read/one-write register bank: operand fetch, 8-bit ALU, write-back, response.
// Optional REGBANK_SEQUENCER_FWD_EN drops the write-to-read wait states and forwards the last write into operand fetch.
module regbank_sequencer (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [2:0] cmd_op,
   input  logic [2:0] cmd_rd,
   input  logic [2:0] cmd_rs1,
   input  logic [2:0] cmd_rs2,
   input  logic [7:0] cmd_imm,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_data,
   output logic       rsp_carry,
   output logic [2:0] reg_addr_1,
   output logic [2:0] reg_addr_2,
   input  logic [7:0] reg_data_1,
   input  logic [7:0] reg_data_2,
   output logic       write_enable,
   output logic [2:0] write_addr,
   output logic [7:0] write_data
);

   typedef enum logic [2:0] {IDLE, OPER, EXEC, WAIT1, WAIT2, RESP} state_t;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_AND  = 3'b010;
   localparam logic [2:0] OP_OR   = 3'b011;
   localparam logic [2:0] OP_XOR  = 3'b100;
   localparam logic [2:0] OP_LDI  = 3'b101;
   localparam logic [2:0] OP_ADDI = 3'b110;
   localparam logic [2:0] OP_RD   = 3'b111;

   state_t     state, state_nxt;
   logic [2:0] op_q, rd_q, rs1_q, rs2_q;
   logic [7:0] imm_q, opa_q, opb_q;
   logic [7:0] opa, opb;
   logic [7:0] result;
   logic       carry;
   logic       writes;
   logic [8:0] sum_rr, sum_ri;

`ifdef REGBANK_SEQUENCER_FWD_EN
   logic [2:0] fwd_addr;
   logic [7:0] fwd_data;
   logic [1:0] fwd_life;

   always_ff @(posedge clk) begin
      if (rst) begin
         fwd_addr <= '0;
         fwd_data <= '0;
         fwd_life <= '0;
      end else if (write_enable) begin
         fwd_addr <= write_addr;
         fwd_data <= write_data;
         fwd_life <= 2'd2;
      end else if (fwd_life != 2'd0) begin
         fwd_life <= fwd_life - 2'd1;
      end
   end

   always_comb begin
      opa = reg_data_1;
      opb = reg_data_2;
      if (fwd_life != 2'd0 && fwd_addr == rs1_q) opa = fwd_data;
      if (fwd_life != 2'd0 && fwd_addr == rs2_q) opb = fwd_data;
      // Register 0 is hard zero; this also keeps it out of forwarding.
      if (rs1_q == 3'd0) opa = '0;
      if (rs2_q == 3'd0) opb = '0;
   end
`else
   always_comb begin
      opa = (rs1_q == 3'd0) ? 8'd0 : reg_data_1;
      opb = (rs2_q == 3'd0) ? 8'd0 : reg_data_2;
   end
`endif

   assign sum_rr = {1'b0, opa_q} + {1'b0, opb_q};
   assign sum_ri = {1'b0, opa_q} + {1'b0, imm_q};
   // rd=0 must never reach the bank: it would alias onto register 1.
   assign writes = (op_q != OP_RD) && (rd_q != 3'd0);

   always_comb begin
      result = '0;
      carry  = 1'b0;
      case (op_q)
         OP_ADD:  begin result = sum_rr[7:0]; carry = sum_rr[8]; end
         OP_SUB:  begin result = opa_q - opb_q; carry = (opa_q < opb_q); end
         OP_AND:  result = opa_q & opb_q;
         OP_OR:   result = opa_q | opb_q;
         OP_XOR:  result = opa_q ^ opb_q;
         OP_LDI:  result = imm_q;
         OP_ADDI: begin result = sum_ri[7:0]; carry = sum_ri[8]; end
         default: result = opa_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_q      <= '0;
         rd_q      <= '0;
         rs1_q     <= '0;
         rs2_q     <= '0;
         imm_q     <= '0;
         opa_q     <= '0;
         opb_q     <= '0;
         rsp_data  <= '0;
         rsp_carry <= 1'b0;
      end else begin
         if (state == IDLE && cmd_valid) begin
            op_q  <= cmd_op;
            rd_q  <= cmd_rd;
            rs1_q <= cmd_rs1;
            rs2_q <= cmd_rs2;
            imm_q <= cmd_imm;
         end
         if (state == OPER) begin
            opa_q <= opa;
            opb_q <= opb;
         end
         if (state == EXEC) begin
            rsp_data  <= result;
            rsp_carry <= carry;
         end
      end
   end

   always_comb begin
      state_nxt    = state;
      cmd_ready    = 1'b0;
      rsp_valid    = 1'b0;
      reg_addr_1   = '0;
      reg_addr_2   = '0;
      write_enable = 1'b0;
      write_addr   = '0;
      write_data   = '0;
      case (state)
         IDLE: begin
            cmd_ready = !rst;
            if (cmd_valid) state_nxt = OPER;
         end
         OPER: begin
            reg_addr_1 = rs1_q;
            reg_addr_2 = rs2_q;
            state_nxt  = EXEC;
         end
         EXEC: begin
            state_nxt = RESP;
            if (writes) begin
               // Gated by rst so a reset landing in EXEC drops the write.
               write_enable = !rst;
               write_addr   = rd_q;
               write_data   = result;
`ifndef REGBANK_SEQUENCER_FWD_EN
               state_nxt    = WAIT1;
`endif
            end
         end
         WAIT1: state_nxt = WAIT2;
         WAIT2: state_nxt = RESP;
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule
